// File: rtl/dla_cdc_pkg.sv
// Shared definitions for the dla clock-domain-crossing blocks: source FSM state
// encoding and the minimum synchronizer depth any crossing may be built with.
package dla_cdc_pkg;

    localparam int MIN_META_STAGES = 2;

    typedef enum logic {
        SRC_IDLE = 1'b0,
        SRC_BUSY = 1'b1
    } src_state_t;

endpackage

// File: rtl/dla_clock_cross_full_sync_internal.sv
// Multi-flop synchronizer: brings i_data into the clk domain through
// METASTABILITY_STAGES flops, all cleared by the asynchronous active-low reset.
module dla_clock_cross_full_sync_internal
    import dla_cdc_pkg::*;
#(
    parameter int WIDTH                = 1,
    parameter int METASTABILITY_STAGES = 3
) (
    input  logic             clk,
    input  logic             i_async_resetn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (METASTABILITY_STAGES < MIN_META_STAGES) begin : g_bad_stages
        $error("METASTABILITY_STAGES (%0d) must be at least %0d",
               METASTABILITY_STAGES, MIN_META_STAGES);
    end

    logic [METASTABILITY_STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge i_async_resetn) begin
        if (!i_async_resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[METASTABILITY_STAGES-2:0], i_data};
        end
    end

    assign o_data = r_sync[METASTABILITY_STAGES-1];

endmodule

// File: rtl/dla_clock_cross_handshake_sync.sv
// Two-phase toggle handshake moving one WIDTH-bit word at a time from clk_src to clk_dst.
// Define DLA_CDC_HANDSHAKE_DST_BUFFER_EN to acknowledge at capture, letting the source launch during a consumer stall.
module dla_clock_cross_handshake_sync
    import dla_cdc_pkg::*;
#(
    parameter int WIDTH                = 32,
    parameter int METASTABILITY_STAGES = 3
) (
    input  logic             clk_src,
    input  logic             i_src_async_resetn,
    input  logic             clk_dst,
    input  logic             i_dst_async_resetn,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    input  logic [WIDTH-1:0] i_src_data,
    output logic             o_dst_valid,
    input  logic             i_dst_ready,
    output logic [WIDTH-1:0] o_dst_data
);

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH (%0d) must be at least 1", WIDTH);
    end

    if (METASTABILITY_STAGES < MIN_META_STAGES) begin : g_bad_stages
        $error("METASTABILITY_STAGES (%0d) must be at least %0d",
               METASTABILITY_STAGES, MIN_META_STAGES);
    end

    src_state_t       r_src_state;
    src_state_t       w_src_state_next;
    logic             r_src_live;
    logic             r_src_req;
    logic [WIDTH-1:0] r_src_hold;
    logic             w_src_ack_sync;
    logic             w_src_accept;

    logic             w_dst_req_sync;
    logic             r_dst_req_seen;
    logic             r_dst_ack;
    logic             r_dst_valid;
    logic [WIDTH-1:0] r_dst_data;
    logic             w_dst_new;
    logic             w_dst_take;
    logic             w_dst_capture;

    dla_clock_cross_full_sync_internal #(
        .WIDTH                (1),
        .METASTABILITY_STAGES (METASTABILITY_STAGES)
    ) u_req_sync (
        .clk            (clk_dst),
        .i_async_resetn (i_dst_async_resetn),
        .i_data         (r_src_req),
        .o_data         (w_dst_req_sync)
    );

    dla_clock_cross_full_sync_internal #(
        .WIDTH                (1),
        .METASTABILITY_STAGES (METASTABILITY_STAGES)
    ) u_ack_sync (
        .clk            (clk_src),
        .i_async_resetn (i_src_async_resetn),
        .i_data         (r_dst_ack),
        .o_data         (w_src_ack_sync)
    );

    always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
        if (!i_src_async_resetn) begin
            r_src_state <= SRC_IDLE;
        end else begin
            r_src_state <= w_src_state_next;
        end
    end

    // The word is home once the returning ack toggle has caught up with our request.
    always_comb begin
        w_src_state_next = r_src_state;
        case (r_src_state)
            SRC_IDLE: if (w_src_accept)                 w_src_state_next = SRC_BUSY;
            SRC_BUSY: if (w_src_ack_sync == r_src_req) w_src_state_next = SRC_IDLE;
            default:                                    w_src_state_next = SRC_IDLE;
        endcase
    end

    // r_src_live keeps ready low until the first clock edge after reset release.
    always_comb begin
        o_src_ready  = r_src_live && (r_src_state == SRC_IDLE);
        w_src_accept = o_src_ready && i_src_valid;
    end

    always_ff @(posedge clk_src or negedge i_src_async_resetn) begin
        if (!i_src_async_resetn) begin
            r_src_live <= 1'b0;
            r_src_req  <= 1'b0;
            r_src_hold <= '0;
        end else begin
            r_src_live <= 1'b1;
            if (w_src_accept) begin
                r_src_hold <= i_src_data;
                r_src_req  <= ~r_src_req;
            end
        end
    end

    // r_src_hold is sampled directly in clk_dst; it is frozen for the whole BUSY window,
    // so it has settled for at least the synchronizer depth before the capture edge.
    always_comb begin
        w_dst_new     = (w_dst_req_sync != r_dst_req_seen);
        w_dst_take    = r_dst_valid && i_dst_ready;
        w_dst_capture = w_dst_new && (!r_dst_valid || i_dst_ready);
    end

    always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
        if (!i_dst_async_resetn) begin
            r_dst_req_seen <= 1'b0;
            r_dst_valid    <= 1'b0;
            r_dst_data     <= '0;
        end else begin
            if (w_dst_capture) begin
                r_dst_req_seen <= w_dst_req_sync;
                r_dst_valid    <= 1'b1;
                r_dst_data     <= r_src_hold;
            end else if (w_dst_take) begin
                r_dst_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_dst or negedge i_dst_async_resetn) begin
        if (!i_dst_async_resetn) begin
            r_dst_ack <= 1'b0;
        end else begin
`ifdef DLA_CDC_HANDSHAKE_DST_BUFFER_EN
            if (w_dst_capture) begin
                r_dst_ack <= w_dst_req_sync;
            end
`else
            if (w_dst_take) begin
                r_dst_ack <= r_dst_req_seen;
            end
`endif
        end
    end

    assign o_dst_valid = r_dst_valid;
    assign o_dst_data  = r_dst_data;

endmodule
